// File: rtl/dac_spi_ctrl.sv
// dac_spi_ctrl: Wishbone (pipelined) slave driving a 24-bit SPI DAC.
// Registers: 0 DATA[23:0], 1 STATUS {overrun, pending, busy}, 2 DIV[7:0], 3 reserved.
// A write to DATA with any of sel[2:0] set requests a frame:
//   IDLE -> SETUP (H clocks) -> SHIFT (24 x 2H clocks) -> GAP (SYNC_GAP x H) -> IDLE
// with H = DIV + 1 system clocks, DIV captured when a frame starts.
// SCLK idles low and each bit period begins with the high half; MOSI moves only on
// SCLK rising edges so the DAC sees stable data on the falling edge.
// Optional feature macro: DAC_SPI_CTRL_PENDING_EN -- queue one request made while busy
// and launch it straight out of GAP. Without it a busy request only updates DATA and
// flags overrun.
// WB_ADDR_WIDTH must be at least 2; SYNC_GAP must be at least 1.
module dac_spi_ctrl #(
    parameter int WB_ADDR_WIDTH = 2,
    parameter int DIV_RESET     = 10,
    parameter int SYNC_GAP      = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic [31:0]              o_wb_data,
    output logic                     o_sclk,
    output logic                     o_mosi,
    output logic                     o_sync_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] LAST_HALF = 16'd47;
    localparam logic [15:0] GAP_LAST  = 16'(SYNC_GAP - 1);
    localparam logic [7:0]  DIV_INIT  = 8'(DIV_RESET);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] half_q;
    logic [7:0]  div_lat_q;
    logic [23:0] shift_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        sync_n_q;
    logic        pending_q;
    logic        overrun_q;
    logic [23:0] data_q;
    logic [23:0] data_d;
    logic [7:0]  div_q;
    logic [7:0]  div_d;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    logic        acc_s;
    logic        wr_s;
    logic [1:0]  addr_s;
    logic        wr_data_s;
    logic        wr_stat_s;
    logic        wr_div_s;
    logic        req_s;
    logic        busy_s;
    logic        half_end_s;
    logic        gap_exit_s;
    logic        start_next_s;
    logic        unused_s;

    assign acc_s      = i_wb_cyc & i_wb_stb;
    assign wr_s       = acc_s & i_wb_we;
    assign addr_s     = i_wb_addr[1:0];
    assign wr_data_s  = wr_s & (addr_s == 2'd0);
    assign wr_stat_s  = wr_s & (addr_s == 2'd1);
    assign wr_div_s   = wr_s & (addr_s == 2'd2);
    assign req_s      = wr_data_s & (|i_wb_sel[2:0]);
    assign busy_s     = (state_q != ST_IDLE);
    assign half_end_s = (cnt_q == div_lat_q);
    assign gap_exit_s = (state_q == ST_GAP) & half_end_s & (half_q == GAP_LAST);
    assign unused_s   = ^{i_wb_sel[3], i_wb_data[31:24]};

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_sclk     = sclk_q;
    assign o_mosi     = mosi_q;
    assign o_sync_n   = sync_n_q;

`ifdef DAC_SPI_CTRL_PENDING_EN
    // A queued request, or one arriving right at GAP exit, launches the next frame.
    assign start_next_s = pending_q | req_s;
`else
    assign start_next_s = 1'b0;
`endif

    // Next DATA value: merge the written byte lanes into the current contents.
    always_comb begin
        data_d = data_q;
        if (wr_data_s) begin
            if (i_wb_sel[0]) data_d[7:0]   = i_wb_data[7:0];   else data_d[7:0]   = data_q[7:0];
            if (i_wb_sel[1]) data_d[15:8]  = i_wb_data[15:8];  else data_d[15:8]  = data_q[15:8];
            if (i_wb_sel[2]) data_d[23:16] = i_wb_data[23:16]; else data_d[23:16] = data_q[23:16];
        end else begin
            data_d = data_q;
        end
    end

    // Next DIV value: only byte lane 0 carries the divider.
    always_comb begin
        div_d = div_q;
        if (wr_div_s && i_wb_sel[0]) begin
            div_d = i_wb_data[7:0];
        end else begin
            div_d = div_q;
        end
    end

    // Read-data multiplexer; unused bits read as zero.
    always_comb begin
        rdata_d = 32'h0000_0000;
        case (addr_s)
            2'd0:    rdata_d = {8'h00, data_q};
            2'd1:    rdata_d = {29'h0000_0000, overrun_q, pending_q, busy_s};
            2'd2:    rdata_d = {24'h00_0000, div_q};
            default: rdata_d = 32'h0000_0000;
        endcase
    end

    // Bus response: single-cycle ack for every accepted access, none during reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            ack_q   <= acc_s;
            rdata_q <= (acc_s && !i_wb_we) ? rdata_d : 32'h0000_0000;
        end
    end

    // Programmable registers DATA and DIV.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= 24'h00_0000;
            div_q  <= DIV_INIT;
        end else begin
            data_q <= data_d;
            div_q  <= div_d;
        end
    end

    // Transfer FSM with registered SPI pins plus pending/overrun bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            half_q    <= 16'd0;
            div_lat_q <= 8'd0;
            shift_q   <= 24'h00_0000;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            sync_n_q  <= 1'b1;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Requests made while a frame is active.
            if (req_s && busy_s) begin
`ifdef DAC_SPI_CTRL_PENDING_EN
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else if (!gap_exit_s) begin
                    pending_q <= 1'b1;
                end
`else
                overrun_q <= 1'b1;
`endif
            end
            if (wr_stat_s) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    sync_n_q <= 1'b1;
                    sclk_q   <= 1'b0;
                    if (req_s) begin
                        state_q   <= ST_SETUP;
                        sync_n_q  <= 1'b0;
                        mosi_q    <= data_d[23];
                        shift_q   <= data_d;
                        div_lat_q <= div_q;
                        cnt_q     <= 8'd0;
                        half_q    <= 16'd0;
                    end
                end
                ST_SETUP: begin
                    if (half_end_s) begin
                        state_q <= ST_SHIFT;
                        sclk_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        half_q  <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (half_end_s) begin
                        cnt_q <= 8'd0;
                        if (half_q == LAST_HALF) begin
                            state_q  <= ST_GAP;
                            sync_n_q <= 1'b1;
                            sclk_q   <= 1'b0;
                            half_q   <= 16'd0;
                        end else begin
                            half_q <= half_q + 16'd1;
                            if (!half_q[0]) begin
                                sclk_q <= 1'b0;
                            end else begin
                                sclk_q  <= 1'b1;
                                mosi_q  <= shift_q[22];
                                shift_q <= {shift_q[22:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (half_end_s) begin
                        cnt_q <= 8'd0;
                        if (half_q == GAP_LAST) begin
                            half_q    <= 16'd0;
                            pending_q <= 1'b0;
                            if (start_next_s) begin
                                state_q   <= ST_SETUP;
                                sync_n_q  <= 1'b0;
                                sclk_q    <= 1'b0;
                                mosi_q    <= data_d[23];
                                shift_q   <= data_d;
                                div_lat_q <= div_q;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            half_q <= half_q + 16'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sync_n_q <= 1'b1;
                    sclk_q   <= 1'b0;
                    cnt_q    <= 8'd0;
                    half_q   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Directed bench for dac_spi_ctrl: bus access tasks, a passive SPI frame monitor
// and one task per scenario with inline expected values.
module tb_dac_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        stall, ack, sclk, mosi, sync_n;
    logic [31:0] rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dac_spi_ctrl #(.WB_ADDR_WIDTH(2), .DIV_RESET(10), .SYNC_GAP(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata),
        .o_sclk(sclk), .o_mosi(mosi), .o_sync_n(sync_n)
    );

    // ---------------- SPI frame monitor (samples just after each rising edge) ----
    int          h_exp = 11;
    int          m_frames = 0, m_starts = 0, m_t = 0, m_bits = 0, m_high = 0;
    int          m_last_bits = 0, m_last_low = 0, m_last_gap = 0;
    int          m_terr = 0, m_glitch = 0, m_idle_err = 0;
    logic [23:0] m_sh = 24'h0, m_last_data = 24'h0, m_prev_data = 24'h0;
    logic        m_prev_sync = 1'b1, m_prev_sclk = 1'b0, m_prev_mosi = 1'b0;

    always begin
        @(posedge clk);
        #2;
        if (sync_n === 1'b0) begin
            if (m_prev_sync) begin
                m_t = 0; m_bits = 0; m_sh = 24'h0; m_last_gap = m_high; m_starts++;
            end else begin
                m_t++;
            end
            if (sclk !== m_prev_sclk) begin
                if ((m_t % h_exp) != 0) m_terr++;
                else if (sclk && (((m_t / h_exp) % 2) == 0)) m_terr++;
                else if (!sclk && (((m_t / h_exp) % 2) == 1)) m_terr++;
                if (!sclk) begin
                    m_sh = {m_sh[22:0], mosi};
                    m_bits++;
                end
            end
            if ((mosi !== m_prev_mosi) && !m_prev_sync && !(sclk && !m_prev_sclk)) m_glitch++;
        end else begin
            if (!m_prev_sync) begin
                m_frames++;
                m_prev_data = m_last_data;
                m_last_data = m_sh;
                m_last_bits = m_bits;
                m_last_low  = m_t + 1;
                m_high      = 0;
            end
            m_high++;
            if (sclk !== 1'b0) m_idle_err++;
        end
        m_prev_sync = sync_n;
        m_prev_sclk = sclk;
        m_prev_mosi = mosi;
    end

    // ---------------- bus access tasks (start and end on a falling edge) --------
    task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic ack_o);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        @(negedge clk);
        ack_o = ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d, output logic ack_o);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        ack_o = ack;
        d = rdata;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while ((m_frames < target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (m_frames < target) begin
            miscompares++;
            $display("FAIL frame_timeout: frames=%0d, expected %0d", m_frames, target);
        end
    endtask

    // ---------------- scenarios -------------------------------------------------
    task automatic test_reset();
        logic a; logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h00FF_FFFF; sel = 4'hF;
        @(negedge clk);
        a = ack;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL ack_in_reset: got %b, expected 0", a); end
        vectors++; if ({sync_n, sclk, mosi, stall} !== 4'b1000) begin miscompares++;
            $display("FAIL reset_pins: got sync/sclk/mosi/stall=%b, expected 1000", {sync_n, sclk, mosi, stall}); end
        wb_read(2'd0, d, a);
        vectors++; if ({a, d} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL reset_data: got ack=%b 0x%0h, expected ack=1 0x0", a, d); end
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got 0x%0h, expected 0x0", d); end
        wb_read(2'd2, d, a);
        vectors++; if (d !== 32'd10) begin miscompares++; $display("FAIL reset_div: got 0x%0h, expected 0xa", d); end
        vectors++; if (m_starts !== 0) begin miscompares++; $display("FAIL reset_no_frame: got %0d starts, expected 0", m_starts); end
    endtask

    task automatic test_basic_frame();
        logic a; logic [31:0] d; int f0, te0, g0;
        wb_write(2'd2, 32'd10, 4'b0001, a);
        h_exp = 11; f0 = m_frames; te0 = m_terr; g0 = m_glitch;
        wb_write(2'd0, 32'h0000_7F22, 4'b0111, a);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL write_ack: got %b, expected 1", a); end
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL busy_status: got 0x%0h, expected 0x1", d); end
        wait_frames(f0 + 1, 1000);
        vectors++; if (m_last_data !== 24'h007F22) begin miscompares++; $display("FAIL basic_data: got 0x%0h, expected 0x7f22", m_last_data); end
        vectors++; if (m_last_bits !== 24) begin miscompares++; $display("FAIL basic_bits: got %0d, expected 24", m_last_bits); end
        vectors++; if (m_last_low !== 539) begin miscompares++; $display("FAIL basic_sync_low: got %0d, expected 539", m_last_low); end
        vectors++; if ((m_terr - te0) !== 0 || (m_glitch - g0) !== 0) begin miscompares++;
            $display("FAIL basic_timing: got %0d timing/%0d glitch errors, expected 0/0", m_terr - te0, m_glitch - g0); end
        // GAP spans 55 clocks after sync_n rises: busy at the 54th, clear at the 55th.
        repeat (52) @(negedge clk);
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL gap_busy: got 0x%0h, expected 0x1", d); end
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL gap_done: got 0x%0h, expected 0x0", d); end
    endtask

    task automatic test_back_to_back();
        logic a; logic [31:0] exp_v [4];
        exp_v[0] = 32'h0000_7F22; exp_v[1] = 32'h0; exp_v[2] = 32'd10; exp_v[3] = 32'h0;
        wb_write(2'd3, 32'hFFFF_FFFF, 4'hF, a);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if ({ack, stall, rdata} !== {1'b1, 1'b0, exp_v[i]}) begin miscompares++;
                $display("FAIL b2b_read%0d: got ack=%b stall=%b 0x%0h, expected ack=1 stall=0 0x%0h", i, ack, stall, rdata, exp_v[i]); end
            addr = 2'(i + 1);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL b2b_extra_ack: got %b, expected 0", ack); end
    endtask

    task automatic test_byte_lane();
        logic a; logic [31:0] d; int f0;
        f0 = m_frames;
        wb_write(2'd0, 32'h0000_AB00, 4'b0010, a);
        wb_read(2'd0, d, a);
        vectors++; if (d !== 32'h00AB22) begin miscompares++; $display("FAIL lane_data: got 0x%0h, expected 0xab22", d); end
        wait_frames(f0 + 1, 1000);
        vectors++; if (m_last_data !== 24'h00AB22) begin miscompares++; $display("FAIL lane_frame: got 0x%0h, expected 0xab22", m_last_data); end
        repeat (60) @(negedge clk);
    endtask

    task automatic test_div0();
        logic a; int f0, te0, g0, i0;
        wb_write(2'd2, 32'd0, 4'b0001, a);
        h_exp = 1; f0 = m_frames; te0 = m_terr; g0 = m_glitch; i0 = m_idle_err;
        wb_write(2'd0, 32'h00A5_A5A5, 4'b0111, a);
        wait_frames(f0 + 1, 200);
        vectors++; if (m_last_data !== 24'hA5A5A5) begin miscompares++; $display("FAIL div0_data: got 0x%0h, expected 0xa5a5a5", m_last_data); end
        vectors++; if (m_last_bits !== 24) begin miscompares++; $display("FAIL div0_bits: got %0d, expected 24", m_last_bits); end
        vectors++; if (m_last_low !== 49) begin miscompares++; $display("FAIL div0_sync_low: got %0d, expected 49", m_last_low); end
        vectors++; if ((m_terr - te0) !== 0 || (m_glitch - g0) !== 0 || (m_idle_err - i0) !== 0) begin miscompares++;
            $display("FAIL div0_glitch: got %0d/%0d/%0d errors, expected 0/0/0", m_terr - te0, m_glitch - g0, m_idle_err - i0); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_div_change();
        logic a; logic [31:0] d; int f0, te0;
        wb_write(2'd2, 32'd2, 4'b0001, a);
        h_exp = 3; f0 = m_frames; te0 = m_terr;
        wb_write(2'd0, 32'h005A_0F3C, 4'b0111, a);
        repeat (10) @(negedge clk);
        wb_write(2'd2, 32'd0, 4'b0001, a);
        wait_frames(f0 + 1, 400);
        vectors++; if (m_last_low !== 147 || (m_terr - te0) !== 0) begin miscompares++;
            $display("FAIL div_midframe: got low=%0d terr=%0d, expected 147 and 0", m_last_low, m_terr - te0); end
        vectors++; if (m_last_data !== 24'h5A0F3C) begin miscompares++; $display("FAIL div_mid_data: got 0x%0h, expected 0x5a0f3c", m_last_data); end
        wb_read(2'd2, d, a);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL div_readback: got 0x%0h, expected 0x0", d); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_pending();
        logic a; logic [31:0] d; int f0, s0;
        wb_write(2'd2, 32'd2, 4'b0001, a);
        h_exp = 3; f0 = m_frames; s0 = m_starts;
        wb_write(2'd0, 32'h0011_1111, 4'b0111, a);
        wb_write(2'd0, 32'h0022_2222, 4'b0111, a);
        wb_read(2'd1, d, a);
`ifdef DAC_SPI_CTRL_PENDING_EN
        vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL pend_status: got 0x%0h, expected 0x3", d); end
        wait_frames(f0 + 2, 1000);
        vectors++; if ({m_prev_data, m_last_data} !== {24'h111111, 24'h222222}) begin miscompares++;
            $display("FAIL pend_frames: got 0x%0h,0x%0h, expected 0x111111,0x222222", m_prev_data, m_last_data); end
        vectors++; if (m_last_gap !== 15) begin miscompares++; $display("FAIL pend_gap: got %0d, expected 15", m_last_gap); end
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL pend_no_overrun: got 0x%0h, expected 0x1", d); end
        repeat (20) @(negedge clk);
        f0 = m_frames;
        wb_write(2'd0, 32'h0033_3333, 4'b0111, a);
        wb_write(2'd0, 32'h0044_4444, 4'b0111, a);
        wb_write(2'd0, 32'h0055_5555, 4'b0111, a);
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h7) begin miscompares++; $display("FAIL pend_overrun: got 0x%0h, expected 0x7", d); end
        wait_frames(f0 + 2, 1000);
        vectors++; if ({m_prev_data, m_last_data} !== {24'h333333, 24'h555555}) begin miscompares++;
            $display("FAIL pend_merge: got 0x%0h,0x%0h, expected 0x333333,0x555555", m_prev_data, m_last_data); end
        repeat (20) @(negedge clk);
`else
        vectors++; if (d !== 32'h5) begin miscompares++; $display("FAIL busy_req_status: got 0x%0h, expected 0x5", d); end
        wait_frames(f0 + 1, 1000);
        vectors++; if (m_last_data !== 24'h111111) begin miscompares++; $display("FAIL busy_req_frame: got 0x%0h, expected 0x111111", m_last_data); end
        repeat (40) @(negedge clk);
        vectors++; if (m_starts !== s0 + 1) begin miscompares++; $display("FAIL busy_req_single: got %0d starts, expected %0d", m_starts, s0 + 1); end
        wb_read(2'd0, d, a);
        vectors++; if (d !== 32'h0022_2222) begin miscompares++; $display("FAIL busy_req_data: got 0x%0h, expected 0x222222", d); end
`endif
    endtask

    task automatic test_overrun_clear();
        logic a; logic [31:0] d;
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h4) begin miscompares++; $display("FAIL overrun_sticky: got 0x%0h, expected 0x4", d); end
        wb_write(2'd1, 32'h0, 4'h0, a);
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL overrun_clear: got 0x%0h, expected 0x0", d); end
    endtask

    task automatic test_div255();
        logic a; int f0, te0;
        wb_write(2'd2, 32'd255, 4'b0001, a);
        h_exp = 256; f0 = m_frames; te0 = m_terr;
        wb_write(2'd0, 32'h0080_0001, 4'b0111, a);
        wait_frames(f0 + 1, 13000);
        vectors++; if (m_last_low !== 12544 || (m_terr - te0) !== 0) begin miscompares++;
            $display("FAIL div255_timing: got low=%0d terr=%0d, expected 12544 and 0", m_last_low, m_terr - te0); end
        vectors++; if (m_last_data !== 24'h800001) begin miscompares++; $display("FAIL div255_data: got 0x%0h, expected 0x800001", m_last_data); end
        repeat (1300) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic a; logic [31:0] d; int s0; int n;
        wb_write(2'd2, 32'd10, 4'b0001, a);
        h_exp = 11; s0 = m_starts; n = 0;
        wb_write(2'd0, 32'h0012_3456, 4'b0111, a);
        while (!((m_starts > s0) && (m_bits >= 12)) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (m_bits < 12) begin miscompares++; $display("FAIL midreset_reach: got %0d bits, expected 12", m_bits); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if ({sync_n, sclk} !== 2'b10) begin miscompares++; $display("FAIL midreset_pins: got sync/sclk=%b, expected 10", {sync_n, sclk}); end
        rst = 1'b0;
        wb_read(2'd0, d, a);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL midreset_data: got 0x%0h, expected 0x0", d); end
        wb_read(2'd2, d, a);
        vectors++; if (d !== 32'd10) begin miscompares++; $display("FAIL midreset_div: got 0x%0h, expected 0xa", d); end
        wb_read(2'd1, d, a);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL midreset_status: got 0x%0h, expected 0x0", d); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_byte_lane();
        test_div0();
        test_div_change();
        test_pending();
        test_overrun_clear();
        test_div255();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
